// File: rtl/icebus_pkg.sv
// icebus register bank shared types: config/status records, register ids, reset defaults
// and field access helpers.
package icebus_pkg;

  typedef struct packed {
    logic signed [31:0] kp;
    logic signed [31:0] ki;
    logic signed [31:0] kd;
    logic signed [31:0] sp;
    logic signed [31:0] pwm_limit;
    logic signed [31:0] integral_limit;
    logic signed [31:0] deadband;
    logic        [7:0]  mode;
  } cfg_t;

  typedef struct packed {
    logic signed [31:0] pos0;
    logic signed [31:0] pos1;
    logic signed [31:0] vel0;
    logic signed [31:0] vel1;
    logic signed [31:0] cur1;
    logic signed [31:0] cur2;
    logic signed [31:0] cur3;
    logic signed [31:0] pwm;
    logic        [31:0] error_code;
    logic        [31:0] crc;
    logic        [31:0] comm_quality;
  } sts_t;

  localparam logic [7:0] REG_ID           = 8'h00;
  localparam logic [7:0] REG_KP           = 8'h01;
  localparam logic [7:0] REG_KI           = 8'h02;
  localparam logic [7:0] REG_KD           = 8'h03;
  localparam logic [7:0] REG_POS0         = 8'h04;
  localparam logic [7:0] REG_POS1         = 8'h05;
  localparam logic [7:0] REG_VEL0         = 8'h06;
  localparam logic [7:0] REG_VEL1         = 8'h07;
  localparam logic [7:0] REG_PWM_LIMIT    = 8'h08;
  localparam logic [7:0] REG_INT_LIMIT    = 8'h09;
  localparam logic [7:0] REG_DEADBAND     = 8'h0A;
  localparam logic [7:0] REG_MODE         = 8'h0B;
  localparam logic [7:0] REG_SP           = 8'h0C;
  localparam logic [7:0] REG_ERROR_CODE   = 8'h0D;
  localparam logic [7:0] REG_UPDATE_FREQ  = 8'h11;
  localparam logic [7:0] REG_CUR1         = 8'h12;
  localparam logic [7:0] REG_CUR2         = 8'h13;
  localparam logic [7:0] REG_CUR3         = 8'h14;
  localparam logic [7:0] REG_CRC          = 8'h15;
  localparam logic [7:0] REG_COMM_QUALITY = 8'h16;
  localparam logic [7:0] REG_PWM          = 8'h17;
  localparam logic [7:0] REG_SEQ          = 8'h18;
  localparam logic [7:0] REG_COMMIT       = 8'h20;
  localparam logic [7:0] REG_DIRTY        = 8'h21;
  localparam logic [7:0] REG_ERR_COUNT    = 8'h22;

  localparam logic [31:0] ID_WORD_DEFAULT  = 32'hB15B0002;
  localparam logic [31:0] UPDATE_FREQ_RST  = 32'd100;
  localparam logic [31:0] ILLEGAL_READ     = 32'hDEADBEEF;

  localparam cfg_t CFG_RESET = '{kp: 32'sd1, ki: '0, kd: '0, sp: '0, pwm_limit: 32'sd127,
                                 integral_limit: 32'sd50, deadband: '0, mode: 8'd0};

  function automatic logic is_cfg_id(input logic [7:0] id);
    return id inside {REG_KP, REG_KI, REG_KD, REG_PWM_LIMIT, REG_INT_LIMIT,
                      REG_DEADBAND, REG_MODE, REG_SP};
  endfunction

  function automatic logic is_sts_id(input logic [7:0] id);
    return id inside {REG_POS0, REG_POS1, REG_VEL0, REG_VEL1, REG_ERROR_CODE, REG_CUR1,
                      REG_CUR2, REG_CUR3, REG_CRC, REG_COMM_QUALITY, REG_PWM};
  endfunction

  // 0x3N mirrors the active copy of config id 0x0N
  function automatic logic is_active_id(input logic [7:0] id);
    return (id[7:4] == 4'h3) && is_cfg_id({4'h0, id[3:0]});
  endfunction

  function automatic logic [31:0] cfg_get(input cfg_t c, input logic [7:0] id);
    logic [31:0] v;
    v = '0;
    case (id)
      REG_KP:        v = c.kp;
      REG_KI:        v = c.ki;
      REG_KD:        v = c.kd;
      REG_SP:        v = c.sp;
      REG_PWM_LIMIT: v = c.pwm_limit;
      REG_INT_LIMIT: v = c.integral_limit;
      REG_DEADBAND:  v = c.deadband;
      REG_MODE:      v = {24'd0, c.mode};
      default:       v = '0;
    endcase
    return v;
  endfunction

  function automatic cfg_t cfg_set(input cfg_t c, input logic [7:0] id, input logic [31:0] v);
    cfg_t r;
    r = c;
    case (id)
      REG_KP:        r.kp             = v;
      REG_KI:        r.ki             = v;
      REG_KD:        r.kd             = v;
      REG_SP:        r.sp             = v;
      REG_PWM_LIMIT: r.pwm_limit      = v;
      REG_INT_LIMIT: r.integral_limit = v;
      REG_DEADBAND:  r.deadband       = v;
      REG_MODE:      r.mode           = v[7:0];
      default:       r = c;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] cfg_sanitize(input logic [7:0] id, input logic [31:0] v,
                                               input int pwm_max);
    logic [31:0] r;
    r = v;
    case (id)
      REG_PWM_LIMIT: begin
        if ($signed(v) < 0)            r = '0;
        else if ($signed(v) > pwm_max) r = 32'(pwm_max);
      end
      REG_INT_LIMIT: if ($signed(v) < 0) r = '0;
      REG_MODE:      r = {24'd0, v[7:0]};
      default:       r = v;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] sts_get(input sts_t s, input logic [7:0] id);
    logic [31:0] v;
    v = '0;
    case (id)
      REG_POS0:         v = s.pos0;
      REG_POS1:         v = s.pos1;
      REG_VEL0:         v = s.vel0;
      REG_VEL1:         v = s.vel1;
      REG_CUR1:         v = s.cur1;
      REG_CUR2:         v = s.cur2;
      REG_CUR3:         v = s.cur3;
      REG_PWM:          v = s.pwm;
      REG_ERROR_CODE:   v = s.error_code;
      REG_CRC:          v = s.crc;
      REG_COMM_QUALITY: v = s.comm_quality;
      default:          v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/icebus_register_bank_channel_regs.sv
// icebus_channel_regs: one motor channel's shadow/active config, dirty flag,
// latched status record and status sequence counter.
module icebus_channel_regs
  import icebus_pkg::*;
#(
  parameter bit AUTO_COMMIT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_we,
  input  logic [7:0]  cfg_id,
  input  logic [31:0] cfg_wdata,
  input  logic        commit,
  input  logic        dirty_clr,
  input  logic        sts_we,
  input  sts_t        sts_in,
  output cfg_t        shadow,
  output cfg_t        active,
  output logic        dirty,
  output sts_t        sts,
  output logic [15:0] seq_count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow    <= CFG_RESET;
      active    <= CFG_RESET;
      dirty     <= 1'b1;
      sts       <= '0;
      seq_count <= '0;
    end else begin
      if (cfg_we) begin
        shadow <= cfg_set(shadow, cfg_id, cfg_wdata);
        if (AUTO_COMMIT) active <= cfg_set(active, cfg_id, cfg_wdata);
      end else if (commit) begin
        active <= shadow;
      end
      // a new commit must not be lost to a clear the transport issued for older data
      if (commit || (cfg_we && AUTO_COMMIT)) dirty <= 1'b1;
      else if (dirty_clr)                    dirty <= 1'b0;
      if (sts_we) begin
        sts       <= sts_in;
        seq_count <= seq_count + 16'd1;
      end
    end
  end

endmodule

// File: rtl/icebus_register_bank.sv
// icebus_register_bank: Avalon-MM slave holding per-channel motor config/status for the
// UART transport; owns decode, read mux, one-wait-state read handshake and error counting.
module icebus_register_bank
  import icebus_pkg::*;
#(
  parameter int          NUM_CHANNELS  = 8,
  parameter bit          AUTO_COMMIT   = 1'b0,
  parameter int          PWM_LIMIT_MAX = 32767,
  parameter logic [31:0] ID_WORD       = ID_WORD_DEFAULT,
  localparam int         CH_W          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             avs_address,
  input  logic                    avs_write,
  input  logic [31:0]             avs_writedata,
  input  logic                    avs_read,
  output logic [31:0]             avs_readdata,
  output logic                    avs_waitrequest,
  input  logic [CH_W-1:0]         xport_cfg_ch,
  output cfg_t                    xport_cfg,
  output logic [NUM_CHANNELS-1:0] xport_dirty,
  input  logic                    xport_dirty_clr,
  input  logic                    xport_sts_valid,
  input  logic [CH_W-1:0]         xport_sts_ch,
  input  sts_t                    xport_sts,
  output logic [31:0]             update_frequency_hz
);

  logic [7:0]      reg_id, reg_ch;
  logic [CH_W-1:0] ch_idx;
  logic            ch_ok, wr_acc, cfg_wr, freq_wr, commit_all, commit_one, wr_illegal;
  logic            rd_done, rd_start, rd_legal;
  logic [31:0]     rd_val, cfg_wdata;
  logic [15:0]     err_count;

  cfg_t        shadow_arr [NUM_CHANNELS];
  cfg_t        active_arr [NUM_CHANNELS];
  sts_t        sts_arr    [NUM_CHANNELS];
  logic [15:0] seq_arr    [NUM_CHANNELS];

  assign reg_id    = avs_address[15:8];
  assign reg_ch    = avs_address[7:0];
  assign ch_idx    = reg_ch[CH_W-1:0];
  assign ch_ok     = {1'b0, reg_ch} < 9'(NUM_CHANNELS);
  assign cfg_wdata = cfg_sanitize(reg_id, avs_writedata, PWM_LIMIT_MAX);

  // a write that overlaps a read is dropped, so writes never see waitrequest
  assign wr_acc     = avs_write && !avs_read;
  assign cfg_wr     = wr_acc && is_cfg_id(reg_id) && ch_ok;
  assign freq_wr    = wr_acc && (reg_id == REG_UPDATE_FREQ);
  assign commit_all = wr_acc && (reg_id == REG_COMMIT) && avs_writedata[8];
  assign commit_one = wr_acc && (reg_id == REG_COMMIT) && !avs_writedata[8] &&
                      ({1'b0, avs_writedata[7:0]} < 9'(NUM_CHANNELS));
  assign wr_illegal = wr_acc && !(cfg_wr || freq_wr || commit_all || commit_one);

  assign rd_start        = avs_read && !rd_done;
  assign avs_waitrequest = rd_start;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    icebus_channel_regs #(.AUTO_COMMIT(AUTO_COMMIT)) u_regs (
      .clk       (clk),
      .reset     (reset),
      .cfg_we    (cfg_wr && (reg_ch == 8'(g))),
      .cfg_id    (reg_id),
      .cfg_wdata (cfg_wdata),
      .commit    (commit_all || (commit_one && (avs_writedata[7:0] == 8'(g)))),
      .dirty_clr (xport_dirty_clr && (xport_cfg_ch == CH_W'(g))),
      .sts_we    (xport_sts_valid && (xport_sts_ch == CH_W'(g))),
      .sts_in    (xport_sts),
      .shadow    (shadow_arr[g]),
      .active    (active_arr[g]),
      .dirty     (xport_dirty[g]),
      .sts       (sts_arr[g]),
      .seq_count (seq_arr[g])
    );
  end

  always_comb begin
    xport_cfg = '0;
    if ({1'b0, xport_cfg_ch} < (CH_W+1)'(NUM_CHANNELS)) xport_cfg = active_arr[xport_cfg_ch];
  end

  always_comb begin
    rd_legal = 1'b1;
    rd_val   = ILLEGAL_READ;
    if (reg_id == REG_ID)                       rd_val = ID_WORD;
    else if (reg_id == REG_UPDATE_FREQ)         rd_val = update_frequency_hz;
    else if (reg_id == REG_ERR_COUNT)           rd_val = {16'd0, err_count};
    else if (ch_ok && is_cfg_id(reg_id))        rd_val = cfg_get(shadow_arr[ch_idx], reg_id);
    else if (ch_ok && is_sts_id(reg_id))        rd_val = sts_get(sts_arr[ch_idx], reg_id);
    else if (ch_ok && (reg_id == REG_SEQ))      rd_val = {16'd0, seq_arr[ch_idx]};
    else if (ch_ok && (reg_id == REG_DIRTY))    rd_val = {31'd0, xport_dirty[ch_idx]};
    else if (ch_ok && is_active_id(reg_id))
      rd_val = cfg_get(active_arr[ch_idx], {4'h0, reg_id[3:0]});
    else                                        rd_legal = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_done             <= 1'b0;
      avs_readdata        <= '0;
      err_count           <= '0;
      update_frequency_hz <= UPDATE_FREQ_RST;
    end else begin
      rd_done <= rd_start;
      if (rd_start) avs_readdata <= rd_val;
      if (((rd_start && !rd_legal) || wr_illegal) && (err_count != 16'hFFFF))
        err_count <= err_count + 16'd1;
      if (freq_wr) update_frequency_hz <= avs_writedata;
    end
  end

endmodule

// File: tb/tb_icebus_register_bank.sv
// Scoreboard bench for icebus_register_bank: a register-map reference model predicts read
// data into a queue that a negedge monitor drains; directed cases plus random traffic.
module tb_icebus_register_bank;
  import icebus_pkg::*;

  localparam int          NCH = 8;
  localparam logic [31:0] IDW = 32'hB15B0002;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] avs_address = '0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [2:0]  xport_cfg_ch = '0;
  cfg_t        xport_cfg;
  logic [NCH-1:0] xport_dirty;
  logic        xport_dirty_clr = 1'b0;
  logic        xport_sts_valid = 1'b0;
  logic [2:0]  xport_sts_ch = '0;
  sts_t        xport_sts = '0;
  logic [31:0] update_frequency_hz;

  icebus_register_bank dut (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_read(avs_read), .avs_readdata(avs_readdata),
    .avs_waitrequest(avs_waitrequest), .xport_cfg_ch(xport_cfg_ch), .xport_cfg(xport_cfg),
    .xport_dirty(xport_dirty), .xport_dirty_clr(xport_dirty_clr),
    .xport_sts_valid(xport_sts_valid), .xport_sts_ch(xport_sts_ch), .xport_sts(xport_sts),
    .update_frequency_hz(update_frequency_hz)
  );

  always #5 clk = ~clk;

  // reference model: register contents indexed by register id
  logic [31:0] m_shadow [NCH][16];
  logic [31:0] m_active [NCH][16];
  logic [31:0] m_sts    [NCH][32];
  int          m_seq    [NCH];
  logic [NCH-1:0] m_dirty;
  int          m_err;
  logic [31:0] m_freq;
  logic [31:0] sts_vals [32];
  logic [31:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int ids [24] = '{0, 1, 2, 3, 4, 5, 8, 9, 10, 11, 12, 13, 14, 17, 18, 23, 24, 32, 33, 34,
                   48, 49, 52, 60};

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_cfg(input int id);
    return id inside {1, 2, 3, 8, 9, 10, 11, 12};
  endfunction

  function automatic bit is_stat(input int id);
    return id inside {4, 5, 6, 7, 13, 18, 19, 20, 21, 22, 23};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      for (int i = 0; i < 16; i++) m_shadow[c][i] = 0;
      m_shadow[c][1] = 1;
      m_shadow[c][8] = 127;
      m_shadow[c][9] = 50;
      for (int i = 0; i < 16; i++) m_active[c][i] = m_shadow[c][i];
      for (int i = 0; i < 32; i++) m_sts[c][i] = 0;
      m_seq[c] = 0;
    end
    for (int i = 0; i < 32; i++) sts_vals[i] = 0;
    m_dirty = '1;
    m_err   = 0;
    m_freq  = 100;
  endtask

  task automatic bump_err();
    if (m_err < 65535) m_err++;
  endtask

  task automatic model_commit(input int c);
    for (int i = 0; i < 16; i++) m_active[c][i] = m_shadow[c][i];
    m_dirty[c] = 1'b1;
  endtask

  function automatic logic [31:0] model_read(input logic [15:0] a, output bit legal);
    int id, ch;
    id = int'(a[15:8]);
    ch = int'(a[7:0]);
    legal = 1'b1;
    if (id == 0)  return IDW;
    if (id == 17) return m_freq;
    if (id == 34) return 32'(m_err);
    if (ch < NCH) begin
      if (is_cfg(id))  return m_shadow[ch][id];
      if (is_stat(id)) return m_sts[ch][id];
      if (id == 24)    return 32'(m_seq[ch]);
      if (id == 33)    return {31'd0, m_dirty[ch]};
      if (id >= 48 && is_cfg(id - 48)) return m_active[ch][id-48];
    end
    legal = 1'b0;
    return 32'hDEADBEEF;
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [31:0] d);
    int id, ch;
    logic [31:0] v;
    id = int'(a[15:8]);
    ch = int'(a[7:0]);
    v  = d;
    if (is_cfg(id) && ch < NCH) begin
      if (id == 8) begin
        if ($signed(d) < 0) v = 0;
        else if ($signed(d) > 32767) v = 32767;
      end else if (id == 9 && $signed(d) < 0) begin
        v = 0;
      end else if (id == 11) begin
        v = d & 32'hFF;
      end
      m_shadow[ch][id] = v;
    end else if (id == 17) begin
      m_freq = d;
    end else if (id == 32 && d[8]) begin
      for (int c = 0; c < NCH; c++) model_commit(c);
    end else if (id == 32 && int'(d[7:0]) < NCH) begin
      model_commit(int'(d[7:0]));
    end else begin
      bump_err();
    end
  endtask

  task automatic apply_sts(input int c);
    for (int i = 0; i < 32; i++) if (is_stat(i)) m_sts[c][i] = sts_vals[i];
    m_seq[c] = (m_seq[c] + 1) % 65536;
  endtask

  task automatic randomize_sts();
    for (int i = 0; i < 32; i++) sts_vals[i] = $urandom;
  endtask

  function automatic sts_t build_sts();
    sts_t s;
    s.pos0 = sts_vals[4];   s.pos1 = sts_vals[5];   s.vel0 = sts_vals[6];
    s.vel1 = sts_vals[7];   s.error_code = sts_vals[13];
    s.cur1 = sts_vals[18];  s.cur2 = sts_vals[19];  s.cur3 = sts_vals[20];
    s.crc  = sts_vals[21];  s.comm_quality = sts_vals[22]; s.pwm = sts_vals[23];
    return s;
  endfunction

  task automatic step(input logic [15:0] a, input bit rd, input bit wr, input logic [31:0] d,
                      input bit clr, input int cch, input bit sv, input int sch);
    @(posedge clk); #1;
    avs_address = a; avs_read = rd; avs_write = wr; avs_writedata = d;
    xport_dirty_clr = clr; xport_cfg_ch = 3'(cch);
    xport_sts_valid = sv;  xport_sts_ch = 3'(sch);
    xport_sts = build_sts();
  endtask

  task automatic op_write(input logic [15:0] a, input logic [31:0] d, input bit clr,
                          input int cch);
    step(a, 1'b0, 1'b1, d, clr, cch, 1'b0, 0);
    if (clr) m_dirty[cch] = 1'b0;
    model_write(a, d);
  endtask

  task automatic op_read(input logic [15:0] a, input bit sv, input int sch);
    bit legal;
    logic [31:0] e;
    step(a, 1'b1, 1'b0, 32'd0, 1'b0, 0, sv, sch);
    e = model_read(a, legal);
    if (!legal) bump_err();
    exp_q.push_back(e);
    if (sv) apply_sts(sch);
    @(negedge clk);
    check("waitrequest in wait cycle", avs_waitrequest, 1);
    @(posedge clk); #1;
    xport_sts_valid = 1'b0;
  endtask

  task automatic op_clr(input int cch);
    step(16'h0000, 1'b0, 1'b0, 32'd0, 1'b1, cch, 1'b0, 0);
    m_dirty[cch] = 1'b0;
  endtask

  task automatic op_sts(input int sch);
    randomize_sts();
    step(16'h0000, 1'b0, 1'b0, 32'd0, 1'b0, 0, 1'b1, sch);
    apply_sts(sch);
  endtask

  task automatic check_state(input int c);
    cfg_t e;
    step(16'h0000, 1'b0, 1'b0, 32'd0, 1'b0, c, 1'b0, 0);
    @(negedge clk);
    e.kp = m_active[c][1];  e.ki = m_active[c][2];  e.kd = m_active[c][3];
    e.sp = m_active[c][12]; e.pwm_limit = m_active[c][8];
    e.integral_limit = m_active[c][9]; e.deadband = m_active[c][10];
    e.mode = m_active[c][11][7:0];
    check("xport_dirty", xport_dirty, m_dirty);
    check("xport_cfg", xport_cfg, e);
    check("update_frequency_hz", update_frequency_hz, m_freq);
  endtask

  // monitor: every completed read pops one prediction
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && avs_read && !avs_waitrequest) begin
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected read response: got %0h with no prediction", avs_readdata);
        end else begin
          check("readdata", avs_readdata, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int kind, ch, id, cch;
    logic [31:0] d;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset waitrequest", avs_waitrequest, 0);
    check("reset readdata", avs_readdata, 0);
    check("reset dirty", xport_dirty, 8'hFF);
    check("reset frequency", update_frequency_hz, 100);
    check_state(0);

    op_read(16'h0100, 1'b0, 0);
    op_read(16'h0000, 1'b0, 0);

    for (int c = 0; c < NCH; c++) op_clr(c);
    check_state(3);
    op_write(16'h0103, 32'd25, 1'b0, 0);
    op_read(16'h0103, 1'b0, 0);
    op_read(16'h3103, 1'b0, 0);
    check_state(3);
    op_write(16'h2000, 32'd3, 1'b0, 0);
    op_read(16'h3103, 1'b0, 0);
    check_state(3);

    op_write(16'h2000, 32'h100, 1'b1, 5);
    check_state(5);
    op_clr(5);
    check_state(0);

    op_write(16'h0800, -32'sd5, 1'b0, 0);
    op_read(16'h0800, 1'b0, 0);
    op_write(16'h0800, 32'd40000, 1'b0, 0);
    op_read(16'h0800, 1'b0, 0);
    op_write(16'h0B00, 32'h1FF, 1'b0, 0);
    op_read(16'h0B00, 1'b0, 0);
    op_write(16'h0901, -32'sd3, 1'b0, 0);
    op_read(16'h0901, 1'b0, 0);

    op_read(16'h0108, 1'b0, 0);
    op_read(16'h2200, 1'b0, 0);
    op_write(16'h0400, 32'd7, 1'b0, 0);
    op_read(16'h0400, 1'b0, 0);
    op_write(16'h2000, 32'd9, 1'b0, 0);
    op_write(16'h0000, 32'd1, 1'b0, 0);
    op_read(16'h2200, 1'b0, 0);

    op_sts(1);
    randomize_sts();
    op_read(16'h0401, 1'b1, 1);
    op_read(16'h0401, 1'b0, 0);
    op_read(16'h1801, 1'b0, 0);

    for (int i = 0; i < 600; i++) begin
      kind = $urandom_range(0, 9);
      ch   = $urandom_range(0, 9);
      id   = ids[$urandom_range(0, 23)];
      cch  = $urandom_range(0, NCH - 1);
      d    = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 60000)) - 32'd30000;
      if (kind <= 3) begin
        randomize_sts();
        op_read({8'(id), 8'(ch)}, $urandom_range(0, 3) == 0, cch);
      end else if (kind <= 6) begin
        op_write({8'(id), 8'(ch)}, d, $urandom_range(0, 1) == 1, cch);
      end else if (kind == 7) begin
        op_write(16'h2000, {23'd0, 1'($urandom_range(0, 3) == 0), 8'(ch)},
                 $urandom_range(0, 1) == 1, cch);
      end else if (kind == 8) begin
        op_sts(cch);
      end else begin
        op_clr(cch);
      end
      if (i % 25 == 0) check_state(cch);
    end

    // concurrent illegal writes and status updates drive err_count into saturation
    for (int i = 0; i < 32; i++) sts_vals[i] = 32'h0;
    sts_vals[4] = 32'hFFFFFC18;
    for (int i = 0; i < 65536; i++) begin
      step(16'h0400, 1'b0, 1'b1, 32'd7, 1'b0, 0, 1'b1, 2);
      model_write(16'h0400, 32'd7);
      apply_sts(2);
    end
    op_read(16'h0402, 1'b0, 0);
    op_read(16'h1802, 1'b0, 0);
    op_read(16'h2200, 1'b0, 0);
    op_read(16'h0108, 1'b0, 0);
    op_read(16'h2200, 1'b0, 0);
    check_state(2);

    repeat (4) step(16'h0000, 1'b0, 1'b0, 32'd0, 1'b0, 0, 1'b0, 0);
    check("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
